fp_mul_param: RTL and testbench

- Parametrised multi-cycle IEEE-754 multiplier. It is the successor of the fixed single-precision FSM multiplier in the FP datapath.
- Generalised in exponent and mantissa width. Adds round-to-nearest-even, a canonical quiet NaN, and per-operation exception flags.
- Uses the same ready/done start-complete handshake. Sits beside the adder and divider behind the FP operand bus.

---
 rtl/fp_mul_param.sv | 237 +++++++++++++++++++++++
 tb/tb_fp_mul_param.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_param.sv
// fp_mul_param: parametrised multi-cycle IEEE-754 multiplier.
//
// Operands are latched on acceptance, classified, then finite operands go
// through multiply / normalise / round / range-check states. Special operands
// (zero, infinity, NaN) take a short path straight to the finish state.
// Denormal inputs are treated as zero. Results flush to zero on underflow and
// saturate to infinity on overflow. Rounding is round-to-nearest-even.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset (aborts any operation)
//   ready          start request, only looked at while idle
//   op1, op2       operands, captured on the accepting edge
//   res            result, updated with done and held until the next done
//   done           one-cycle completion pulse
//   busy           high whenever the unit is not idle
//   flag_invalid   NaN operand or zero times infinity
//   flag_overflow  finite operands produced a result saturated to infinity
//   flag_underflow nonzero finite result flushed to zero
//   flag_inexact   delivered result differs from the exact product
//
// Handshake: while busy=0, ready=1 at a rising edge starts an operation with
// the op1/op2 present at that edge and busy rises. Exactly one done pulse
// follows (2 cycles later on the special path, 5 on the normal path); res and
// the flags change at that same edge. The cycle after done is idle, so a
// held ready starts the next operation immediately.
module fp_mul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ready,
  input  logic [EXP_W+MAN_W:0]   op1,
  input  logic [EXP_W+MAN_W:0]   op2,
  output logic [EXP_W+MAN_W:0]   res,
  output logic                   done,
  output logic                   busy,
  output logic                   flag_invalid,
  output logic                   flag_overflow,
  output logic                   flag_underflow,
  output logic                   flag_inexact
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;

  localparam logic [EXP_W-1:0] EMAX   = {EXP_W{1'b1}};
  localparam logic [EXP_W+1:0] EMAX_X = {2'b00, {EXP_W{1'b1}}};
  localparam logic [EXP_W+1:0] BIAS_X = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [EXP_W+1:0] ONE_X  = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic [W-1:0]     QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLASS,
    ST_MULT,
    ST_NORM,
    ST_ROUND,
    ST_FINISH
  } state_t;

  state_t state, state_next;

  // Datapath registers
  logic [W-1:0]       a_r, b_r;
  logic               sign_r;
  logic               spec_r;
  logic [W-1:0]       spec_res_r;
  logic               spec_inv_r;
  logic [PW-1:0]      p_r;
  // Biased exponent carried with two extra bits: MSB is the sign so that
  // underflowed (negative) exponents stay distinguishable from large ones.
  logic [EXP_W+1:0]   e_r;
  logic [MAN_W-1:0]   frac_r;
  logic               guard_r, sticky_r, inexact_r;

  // Operand fields and classification
  logic [EXP_W-1:0] e1, e2;
  logic [MAN_W-1:0] f1, f2;
  logic             zero1, zero2, inf1, inf2, nan1, nan2;
  logic             special, sign_x;
  logic [W-1:0]     spec_res;
  logic             spec_inv;

  always_comb begin
    e1      = a_r[W-2 -: EXP_W];
    e2      = b_r[W-2 -: EXP_W];
    f1      = a_r[MAN_W-1:0];
    f2      = b_r[MAN_W-1:0];
    sign_x  = a_r[W-1] ^ b_r[W-1];
    zero1   = (e1 == '0);
    zero2   = (e2 == '0);
    inf1    = (e1 == EMAX) && (f1 == '0);
    inf2    = (e2 == EMAX) && (f2 == '0);
    nan1    = (e1 == EMAX) && (f1 != '0);
    nan2    = (e2 == EMAX) && (f2 != '0);
    special = zero1 | zero2 | inf1 | inf2 | nan1 | nan2;
    spec_res = '0;
    spec_inv = 1'b0;
    if (nan1 || nan2 || (zero1 && inf2) || (inf1 && zero2)) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (zero1 || zero2) begin
      spec_res = {sign_x, {(W-1){1'b0}}};
    end else begin
      spec_res = {sign_x, EMAX, {MAN_W{1'b0}}};
    end
  end

  // Normalisation: the product of two [1,2) significands lies in [1,4), so
  // the leading one sits in one of the top two bits.
  logic [PW-1:0]    pn;
  logic [MAN_W-1:0] frac_n;
  logic             guard_n, sticky_n;

  always_comb begin
    pn       = p_r[PW-1] ? p_r : (p_r << 1);
    frac_n   = pn[PW-2 -: MAN_W];
    guard_n  = pn[PW-2-MAN_W];
    sticky_n = |pn[PW-3-MAN_W:0];
  end

  // Rounding increment; a carry out of the fraction means the significand
  // became exactly 2.0, which is fraction 0 with the exponent bumped.
  logic             inc, carry;
  logic [MAN_W-1:0] frac_rnd;

  always_comb begin
    inc              = guard_r & (sticky_r | frac_r[0]);
    {carry, frac_rnd} = {1'b0, frac_r} + {{MAN_W{1'b0}}, inc};
  end

  // Range check and final assembly of the normal path
  logic [W-1:0] fin_res;
  logic         fin_ovf, fin_unf, fin_inx;

  always_comb begin
    fin_res = {sign_r, e_r[EXP_W-1:0], frac_r};
    fin_ovf = 1'b0;
    fin_unf = 1'b0;
    fin_inx = inexact_r;
    if (!e_r[EXP_W+1] && (e_r >= EMAX_X)) begin
      fin_res = {sign_r, EMAX, {MAN_W{1'b0}}};
      fin_ovf = 1'b1;
      fin_inx = 1'b1;
    end else if (e_r[EXP_W+1] || (e_r == '0)) begin
      fin_res = {sign_r, {(W-1){1'b0}}};
      fin_unf = 1'b1;
      fin_inx = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (ready) state_next = ST_CLASS;
      ST_CLASS:  state_next = special ? ST_FINISH : ST_MULT;
      ST_MULT:   state_next = ST_NORM;
      ST_NORM:   state_next = ST_ROUND;
      ST_ROUND:  state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      res            <= '0;
      done           <= 1'b0;
      flag_invalid   <= 1'b0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_inexact   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ready) begin
            a_r            <= op1;
            b_r            <= op2;
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
          end
        end
        ST_CLASS: begin
          sign_r     <= sign_x;
          spec_r     <= special;
          spec_res_r <= spec_res;
          spec_inv_r <= spec_inv;
        end
        ST_MULT: begin
          p_r <= {{SW{1'b0}}, 1'b1, f1} * {{SW{1'b0}}, 1'b1, f2};
          e_r <= {2'b00, e1} + {2'b00, e2} - BIAS_X;
        end
        ST_NORM: begin
          if (p_r[PW-1]) e_r <= e_r + ONE_X;
          frac_r   <= frac_n;
          guard_r  <= guard_n;
          sticky_r <= sticky_n;
        end
        ST_ROUND: begin
          frac_r    <= frac_rnd;
          if (carry) e_r <= e_r + ONE_X;
          inexact_r <= guard_r | sticky_r;
        end
        ST_FINISH: begin
          done <= 1'b1;
          if (spec_r) begin
            res          <= spec_res_r;
            flag_invalid <= spec_inv_r;
          end else begin
            res            <= fin_res;
            flag_overflow  <= fin_ovf;
            flag_underflow <= fin_unf;
            flag_inexact   <= fin_inx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_param.sv
// tb_fp_mul_param: bench for fp_mul_param, single precision (8/23) and
// half precision (5/10) instances sharing one clock and reset.
module tb_fp_mul_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- single precision DUT ----------------
  logic        ready_s = 1'b0;
  logic [31:0] op1_s = '0, op2_s = '0;
  logic [31:0] res_s;
  logic        done_s, busy_s, inv_s, ovf_s, unf_s, inx_s;

  fp_mul_param #(.EXP_W(8), .MAN_W(23)) dut_s (
    .clk(clk), .rst(rst), .ready(ready_s), .op1(op1_s), .op2(op2_s),
    .res(res_s), .done(done_s), .busy(busy_s),
    .flag_invalid(inv_s), .flag_overflow(ovf_s),
    .flag_underflow(unf_s), .flag_inexact(inx_s)
  );

  // ---------------- half precision DUT ----------------
  logic        ready_h = 1'b0;
  logic [15:0] op1_h = '0, op2_h = '0;
  logic [15:0] res_h;
  logic        done_h, busy_h, inv_h, ovf_h, unf_h, inx_h;

  fp_mul_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .ready(ready_h), .op1(op1_h), .op2(op2_h),
    .res(res_h), .done(done_h), .busy(busy_h),
    .flag_invalid(inv_h), .flag_overflow(ovf_h),
    .flag_underflow(unf_h), .flag_inexact(inx_h)
  );

  // ---------------- reference model ----------------
  // Value-level IEEE multiply: exact integer product of the significands,
  // rounded by comparing the discarded remainder with one half ulp.
  // fl = {invalid, overflow, underflow, inexact}; spec = special-path op.
  function automatic void model(input int ew, input int mw,
                                input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [3:0] fl,
                                output bit spec);
    longint emax, bias, ex, ey, fx, fy, s, p, e, m, rem, half, rr, mask;
    int     w, sh;
    bit     zx, zy, ix, iy, nx, ny, inexact;
    w    = 1 + ew + mw;
    emax = (longint'(1) << ew) - 1;
    bias = (longint'(1) << (ew - 1)) - 1;
    mask = (longint'(1) << mw) - 1;
    ex   = ({32'h0, x} >> mw) & emax;
    ey   = ({32'h0, y} >> mw) & emax;
    fx   = {32'h0, x} & mask;
    fy   = {32'h0, y} & mask;
    s    = (({32'h0, x} >> (w - 1)) ^ ({32'h0, y} >> (w - 1))) & 1;
    zx = (ex == 0);  zy = (ey == 0);
    ix = (ex == emax) && (fx == 0);  iy = (ey == emax) && (fy == 0);
    nx = (ex == emax) && (fx != 0);  ny = (ey == emax) && (fy != 0);
    fl   = 4'b0000;
    spec = 1'b1;
    if (nx || ny || (zx && iy) || (ix && zy)) begin
      rr = (emax << mw) | (longint'(1) << (mw - 1));
      fl = 4'b1000;
    end else if (zx || zy) begin
      rr = s << (w - 1);
    end else if (ix || iy) begin
      rr = (s << (w - 1)) | (emax << mw);
    end else begin
      spec = 1'b0;
      p = ((longint'(1) << mw) | fx) * ((longint'(1) << mw) | fy);
      e = ex + ey - bias;
      if (p >= (longint'(1) << (2 * mw + 1))) begin
        sh = mw + 1;
        e  = e + 1;
      end else begin
        sh = mw;
      end
      m    = p >> sh;
      rem  = p & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      inexact = (rem != 0);
      if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
      if (m == (longint'(1) << (mw + 1))) begin
        m = m >> 1;
        e = e + 1;
      end
      if (e >= emax) begin
        rr = (s << (w - 1)) | (emax << mw);
        fl = 4'b0101;
      end else if (e <= 0) begin
        rr = s << (w - 1);
        fl = 4'b0011;
      end else begin
        rr = (s << (w - 1)) | (e << mw) | (m & mask);
        fl = {3'b000, inexact};
      end
    end
    r = 32'(rr);
  endfunction

  // Operand generator biased toward zeros, infinities, NaNs and extreme
  // exponents so that every result class shows up.
  function automatic logic [31:0] rand_op(input int ew, input int mw);
    longint emax, e, f, mask, s;
    int sel, fsel;
    emax = (longint'(1) << ew) - 1;
    mask = (longint'(1) << mw) - 1;
    sel  = $urandom_range(0, 15);
    fsel = $urandom_range(0, 7);
    if (sel == 0)      e = 0;
    else if (sel == 1) e = emax;
    else if (sel <= 3) e = $urandom_range(1, 4);
    else if (sel <= 5) e = emax - $urandom_range(1, 4);
    else               e = $urandom_range(1, 32'(emax - 1));
    if (fsel == 0)      f = 0;
    else if (fsel == 1) f = 1;
    else if (fsel == 2) f = mask;
    else                f = {32'h0, $urandom} & mask;
    s = $urandom_range(0, 1);
    return 32'((s << (ew + mw)) | (e << mw) | f);
  endfunction

  // ---------------- driver ----------------
  // Issues one operation to the selected DUT (which must be idle) and waits,
  // bounded, for done. lat = cycles from acceptance to done (20 on timeout);
  // bsy = number of sampled cycles with busy high before done.
  task automatic run(input bit half, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] r, output logic [3:0] fl,
                     output int lat, output int bsy);
    @(negedge clk);
    if (half) begin
      ready_h = 1'b1; op1_h = a[15:0]; op2_h = b[15:0];
    end else begin
      ready_s = 1'b1; op1_s = a; op2_s = b;
    end
    @(negedge clk);
    ready_h = 1'b0;
    ready_s = 1'b0;
    lat = 0;
    bsy = 0;
    while (!(half ? done_h : done_s) && lat < 20) begin
      if (half ? busy_h : busy_s) bsy++;
      @(negedge clk);
      lat++;
    end
    if (half ? busy_h : busy_s) bsy += 100;
    r  = half ? {16'h0, res_h} : res_s;
    fl = half ? {inv_h, ovf_h, unf_h, inx_h} : {inv_s, ovf_s, unf_s, inx_s};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({res_s, done_s, busy_s, inv_s, ovf_s, unf_s, inx_s} !== 38'h0) begin
      failures++;
      $display("FAIL reset_single: got res=%h done=%b busy=%b flags=%b%b%b%b want all zero",
               res_s, done_s, busy_s, inv_s, ovf_s, unf_s, inx_s);
    end
    checks++;
    if ({res_h, done_h, busy_h, inv_h, ovf_h, unf_h, inx_h} !== 22'h0) begin
      failures++;
      $display("FAIL reset_half: got res=%h done=%b busy=%b flags=%b%b%b%b want all zero",
               res_h, done_h, busy_h, inv_h, ovf_h, unf_h, inx_h);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [31:0] ta [14] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h7F800000,
                             32'h80000000, 32'h7FA00000, 32'h7F7FFFFF, 32'h00800000,
                             32'h00400000, 32'h3F7FFFFF, 32'h3F800001,
                             32'h00003C00, 32'h00007BFF, 32'h00007C00};
    logic [31:0] tb [14] = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h00000000,
                             32'h3F800000, 32'h3F800000, 32'h40000000, 32'h00800000,
                             32'h3F800000, 32'h3F800001, 32'h3FC00000,
                             32'h00004000, 32'h00004000, 32'h00000000};
    logic [31:0] tr [14] = '{32'h40400000, 32'hC0C00000, 32'h3F800002, 32'h7FC00000,
                             32'h80000000, 32'h7FC00000, 32'h7F800000, 32'h00000000,
                             32'h00000000, 32'h3F800000, 32'h3FC00002,
                             32'h00004000, 32'h00007C00, 32'h00007E00};
    logic [3:0]  tf [14] = '{4'b0000, 4'b0000, 4'b0001, 4'b1000,
                             4'b0000, 4'b1000, 4'b0101, 4'b0011,
                             4'b0000, 4'b0001, 4'b0001,
                             4'b0000, 4'b0101, 4'b1000};
    int          tl [14] = '{5, 5, 5, 2, 2, 2, 5, 5, 2, 5, 5, 5, 5, 2};
    logic [31:0] r;
    logic [3:0]  fl;
    int          lat, bsy;
    bit          half;
    for (int i = 0; i < 14; i++) begin
      half = (i >= 11);
      run(half, ta[i], tb[i], r, fl, lat, bsy);
      checks++;
      if (r !== tr[i] || fl !== tf[i]) begin
        failures++;
        $display("FAIL directed_%0d: %h*%h got res=%h flags=%b want res=%h flags=%b",
                 i, ta[i], tb[i], r, fl, tr[i], tf[i]);
      end
      checks++;
      if (lat !== tl[i] || bsy !== tl[i]) begin
        failures++;
        $display("FAIL directed_latency_%0d: got lat=%0d busy_cycles=%0d want %0d and %0d",
                 i, lat, bsy, tl[i], tl[i]);
      end
    end
  endtask

  task automatic test_random(input bit half, input int n);
    logic [31:0] a, b, r, er;
    logic [3:0]  fl, ef;
    int          lat, bsy, ew, mw;
    bit          spec;
    ew = half ? 5 : 8;
    mw = half ? 10 : 23;
    for (int i = 0; i < n; i++) begin
      a = rand_op(ew, mw);
      b = rand_op(ew, mw);
      model(ew, mw, a, b, er, ef, spec);
      run(half, a, b, r, fl, lat, bsy);
      checks++;
      if (r !== er || fl !== ef || lat !== (spec ? 2 : 5)) begin
        failures++;
        $display("FAIL random_%s_%0d: %h*%h got res=%h flags=%b lat=%0d want res=%h flags=%b lat=%0d",
                 half ? "half" : "single", i, a, b, r, fl, lat, er, ef, spec ? 2 : 5);
      end
    end
  endtask

  // Result and flags hold through a new operation; flags clear on acceptance.
  task automatic test_hold;
    logic [31:0] r;
    logic [3:0]  fl;
    int          lat, bsy, n;
    run(1'b0, 32'h3F800001, 32'h3F800001, r, fl, lat, bsy);
    @(negedge clk);
    ready_s = 1'b1; op1_s = 32'h3FC00000; op2_s = 32'h40000000;
    @(negedge clk);
    ready_s = 1'b0;
    checks++;
    if (res_s !== 32'h3F800002 || {inv_s, ovf_s, unf_s, inx_s} !== 4'b0000 || busy_s !== 1'b1) begin
      failures++;
      $display("FAIL hold_at_accept: got res=%h flags=%b%b%b%b busy=%b want res=3f800002 flags=0000 busy=1",
               res_s, inv_s, ovf_s, unf_s, inx_s, busy_s);
    end
    n = 0;
    while (!done_s && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (res_s !== 32'h40400000 || n !== 5) begin
      failures++;
      $display("FAIL hold_complete: got res=%h lat=%0d want res=40400000 lat=5", res_s, n);
    end
  endtask

  // Ready held high: each op is accepted in the idle cycle right after the
  // previous done; results come back in order at the predicted cycle.
  task automatic test_back_to_back;
    logic [35:0] exp_q[$];
    int          due_q[$];
    logic [31:0] a, b, er;
    logic [3:0]  ef;
    logic [35:0] e;
    bit          spec, prev_done;
    int          pushed, seen, cyc, due;
    pushed = 0; seen = 0; cyc = 0; prev_done = 0;
    while ((pushed < 10 || exp_q.size() > 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done_s) begin
        checks++;
        if (exp_q.size() == 0 || prev_done) begin
          failures++;
          $display("FAIL b2b_spurious_done: cycle %0d res=%h with nothing outstanding", cyc, res_s);
        end else begin
          e   = exp_q.pop_front();
          due = due_q.pop_front();
          seen++;
          if ({inv_s, ovf_s, unf_s, inx_s, res_s} !== e || cyc !== due) begin
            failures++;
            $display("FAIL b2b_result_%0d: got res=%h flags=%b%b%b%b cycle=%0d want res=%h flags=%b cycle=%0d",
                     seen, res_s, inv_s, ovf_s, unf_s, inx_s, cyc, e[31:0], e[35:32], due);
          end
        end
      end
      prev_done = done_s;
      if (!busy_s) begin
        if (pushed < 10) begin
          a = rand_op(8, 23);
          b = rand_op(8, 23);
          model(8, 23, a, b, er, ef, spec);
          ready_s = 1'b1; op1_s = a; op2_s = b;
          exp_q.push_back({ef, er});
          due_q.push_back(cyc + 1 + (spec ? 2 : 5));
          pushed++;
        end else begin
          ready_s = 1'b0;
        end
      end
    end
    ready_s = 1'b0;
    checks++;
    if (seen !== 10 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_count: got %0d completions, %0d outstanding; want 10 and 0",
               seen, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] r;
    logic [3:0]  fl;
    int          lat, bsy, dones;
    run(1'b0, 32'h3F800001, 32'h3F800001, r, fl, lat, bsy);
    @(negedge clk);
    ready_s = 1'b1; op1_s = 32'h40000000; op2_s = 32'h40400000;
    @(negedge clk);
    ready_s = 1'b0;
    repeat (3) @(negedge clk);      // now in the rounding state
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (done_s !== 1'b0 || busy_s !== 1'b0 || res_s !== 32'h0 || inx_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_op: got done=%b busy=%b res=%h inexact=%b want 0 0 00000000 0",
               done_s, busy_s, res_s, inx_s);
    end
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_s) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL reset_mid_op_no_done: got %0d done pulses want 0", dones);
    end
    run(1'b0, 32'h40000000, 32'h40400000, r, fl, lat, bsy);
    checks++;
    if (r !== 32'h40C00000 || fl !== 4'b0000 || lat !== 5) begin
      failures++;
      $display("FAIL reset_mid_op_recover: got res=%h flags=%b lat=%0d want 40c00000 0000 5",
               r, fl, lat);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random(1'b0, 300);
    test_random(1'b1, 200);
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
